// File: rtl/packet_receiver_pkg.sv
// Shared definitions for the telemetry packet receive path.
// Holds the payload/packet size formulas, header field offsets, error codes,
// the receiver state type and the ASCII-hex decode helper (also used by the
// command parser).
package packet_receiver_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DRAIN,
    S_CHECK
  } state_t;

  localparam int HDR_W  = 64;
  localparam int FOOT_W = 64;

  // Header field LSB positions (header is the first 64 bits on the wire).
  localparam int HDR_RES_LSB  = 56;
  localparam int HDR_NIN_LSB  = 48;
  localparam int HDR_DLY_LSB  = 36;
  localparam int HDR_LAGA_LSB = 28;
  localparam int HDR_LAGC_LSB = 20;
  localparam int HDR_FLAG_LSB = 16;
  localparam int HDR_TICK_LSB = 0;

  localparam logic [2:0] ERR_SHORT   = 3'd1;
  localparam logic [2:0] ERR_LONG    = 3'd2;
  localparam logic [2:0] ERR_BADCHAR = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_HEADER  = 3'd5;

  localparam logic [7:0] CHAR_CR = 8'h0D;

  function automatic int payload_size(input int num_inputs, input int lag_auto,
                                      input int lag_cross, input int has_cc,
                                      input int resolution);
    int nb;
    nb = num_inputs * (num_inputs - 1) / 2;
    return ((has_cc * nb * (2 * lag_cross - 1) + num_inputs * lag_auto) * 2
            + num_inputs) * resolution;
  endfunction

  function automatic int packet_size(input int payload_bits);
    return payload_bits + HDR_W + FOOT_W;
  endfunction

  // Returns {is_hex, nibble}; nibble is 0 for non-hex characters.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    return 5'b0_0000;
  endfunction

endpackage

// File: rtl/packet_receiver_hex_nibble_decoder.sv
// Combinational ASCII-hex character decoder.
// Ports: ch (8-bit character in), nibble (4-bit value out), is_hex (char is
// one of 0-9, A-F, a-f).
module hex_nibble_decoder
  import packet_receiver_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    {is_hex, nibble} = hex_to_nibble(ch);
  end

endmodule

// File: rtl/packet_receiver.sv
// Receive side of the correlator telemetry link: reassembles one packet
// (64-bit header, payload, 64-bit timestamp footer, MSB first) from a byte
// stream, validates the header and presents the fields in parallel.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_data, rx_valid     incoming byte and its one-cycle strobe
//   payload, timestamp,   fields of the last good packet
//   tick
//   pkt_valid, pkt_error  one-cycle pulses per good / bad packet
//   error_code            cause of the last error (held)
//   pkt_count, err_count  saturating good / bad packet counters
module packet_receiver
  import packet_receiver_pkg::*;
#(
  parameter int NUM_INPUTS          = 2,
  parameter int LAG_AUTO            = 1,
  parameter int LAG_CROSS           = 1,
  parameter int DELAY_SIZE          = 0,
  parameter int RESOLUTION          = 8,
  parameter int HAS_CROSSCORRELATOR = 1,
  parameter int BINARY              = 0,
  parameter int TIMEOUT_CYCLES      = 1000000,
  localparam int PAYLOAD_SIZE = payload_size(NUM_INPUTS, LAG_AUTO, LAG_CROSS,
                                             HAS_CROSSCORRELATOR, RESOLUTION)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [PAYLOAD_SIZE-1:0] payload,
  output logic [63:0]             timestamp,
  output logic [15:0]             tick,
  output logic                    pkt_valid,
  output logic                    pkt_error,
  output logic [2:0]              error_code,
  output logic [15:0]             pkt_count,
  output logic [15:0]             err_count
);

  localparam int PACKET_SIZE = packet_size(PAYLOAD_SIZE);
  localparam logic [15:0] N_UNITS = 16'((BINARY != 0) ? PACKET_SIZE / 8 : PACKET_SIZE / 4);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [PACKET_SIZE-1:0] shift_q;
  logic [PACKET_SIZE-1:0] shift_next;
  logic [15:0]            cnt;
  logic [31:0]            gap;
  logic                   pend_valid;
  logic [7:0]             pend_data;

  logic                   in_valid;
  logic [7:0]             in_data;
  logic [3:0]             nibble;
  logic                   is_hex;
  logic                   is_cr;
  logic                   timeout;
  logic [63:0]            hdr;
  logic                   hdr_ok;
  logic                   err_fire;
  logic [2:0]             err_code_n;

  // A byte that lands during the single CHECK cycle is held for one cycle
  // and replayed in IDLE, so it still starts the next packet.
  always_comb begin
    in_valid = rx_valid | pend_valid;
    in_data  = pend_valid ? pend_data : rx_data;
  end

  hex_nibble_decoder u_dec (
    .ch     (in_data),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  always_comb begin
    is_cr   = (in_data == CHAR_CR);
    timeout = !in_valid && (gap == TO_LIM);
    if (BINARY != 0) shift_next = {shift_q[PACKET_SIZE-9:0], in_data};
    else             shift_next = {shift_q[PACKET_SIZE-5:0], nibble};
  end

  // Header check; tick and flags[3:1] are don't-care.
  always_comb begin
    hdr    = shift_q[PACKET_SIZE-1 -: 64];
    hdr_ok = (hdr[HDR_RES_LSB  +: 8]  == 8'(RESOLUTION))
          && (hdr[HDR_NIN_LSB  +: 8]  == 8'(NUM_INPUTS - 1))
          && (hdr[HDR_DLY_LSB  +: 12] == 12'(DELAY_SIZE))
          && (hdr[HDR_LAGA_LSB +: 8]  == 8'(LAG_AUTO - 1))
          && (hdr[HDR_LAGC_LSB +: 8]  == 8'(LAG_CROSS - 1))
          && ((hdr[HDR_FLAG_LSB +: 4] & 4'h1) == 4'(HAS_CROSSCORRELATOR));
  end

  // Error detection per state; at most one error per cycle, and each bad
  // packet produces exactly one because every error exits SHIFT/CHECK.
  always_comb begin
    err_fire   = 1'b0;
    err_code_n = '0;
    case (state)
      S_IDLE: begin
        if (in_valid && BINARY == 0 && !is_hex && !is_cr) begin
          err_fire = 1'b1; err_code_n = ERR_BADCHAR;
        end
      end
      S_SHIFT: begin
        if (in_valid) begin
          if (BINARY == 0) begin
            if (is_cr) begin
              if (cnt != N_UNITS) begin err_fire = 1'b1; err_code_n = ERR_SHORT; end
            end else if (is_hex) begin
              if (cnt == N_UNITS) begin err_fire = 1'b1; err_code_n = ERR_LONG; end
            end else begin
              err_fire = 1'b1; err_code_n = ERR_BADCHAR;
            end
          end
        end else if (timeout) begin
          err_fire = 1'b1; err_code_n = ERR_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (timeout) begin err_fire = 1'b1; err_code_n = ERR_TIMEOUT; end
      end
      S_CHECK: begin
        if (!hdr_ok) begin err_fire = 1'b1; err_code_n = ERR_HEADER; end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      cnt        <= '0;
      gap        <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      payload    <= '0;
      timestamp  <= '0;
      tick       <= '0;
      pkt_valid  <= 1'b0;
      pkt_error  <= 1'b0;
      error_code <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      pkt_valid  <= 1'b0;
      pkt_error  <= 1'b0;
      pend_valid <= 1'b0;

      if (err_fire) begin
        pkt_error  <= 1'b1;
        error_code <= err_code_n;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end

      if (in_valid)                               gap <= '0;
      else if (state == S_SHIFT || state == S_DRAIN) gap <= gap + 1'b1;
      else                                        gap <= '0;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (BINARY != 0 || is_hex) begin
              shift_q <= shift_next;
              cnt     <= 16'd1;
              state   <= S_SHIFT;
            end else if (!is_cr) begin
              state <= S_DRAIN;
            end
          end
        end
        S_SHIFT: begin
          if (in_valid) begin
            if (BINARY != 0) begin
              shift_q <= shift_next;
              cnt     <= cnt + 16'd1;
              if (cnt + 16'd1 == N_UNITS) state <= S_CHECK;
            end else if (is_cr) begin
              state <= (cnt == N_UNITS) ? S_CHECK : S_IDLE;
            end else if (is_hex) begin
              if (cnt == N_UNITS) begin
                state <= S_DRAIN;
              end else begin
                shift_q <= shift_next;
                cnt     <= cnt + 16'd1;
              end
            end else begin
              state <= S_DRAIN;
            end
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (in_valid) begin
            if (is_cr) state <= S_IDLE;
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          if (hdr_ok) begin
            payload   <= shift_q[PAYLOAD_SIZE+FOOT_W-1:FOOT_W];
            timestamp <= shift_q[FOOT_W-1:0];
            tick      <= hdr[HDR_TICK_LSB +: 16];
            pkt_valid <= 1'b1;
            if (pkt_count != '1) pkt_count <= pkt_count + 1'b1;
          end
          if (rx_valid) begin
            pend_valid <= 1'b1;
            pend_data  <= rx_data;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
module tb_packet_receiver;

  localparam int PS    = 64;
  localparam int HEX_N = 48;
  localparam int BIN_N = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [7:0]    h_data, b_data;
  logic          h_valid, b_valid;
  logic [PS-1:0] h_payload, b_payload;
  logic [63:0]   h_ts, b_ts;
  logic [15:0]   h_tick, b_tick, h_pc, b_pc, h_ec, b_ec;
  logic          h_pv, b_pv, h_pe, b_pe;
  logic [2:0]    h_code, b_code;

  packet_receiver #(.BINARY(0)) u_hex (
    .clk(clk), .reset(reset), .rx_data(h_data), .rx_valid(h_valid),
    .payload(h_payload), .timestamp(h_ts), .tick(h_tick),
    .pkt_valid(h_pv), .pkt_error(h_pe), .error_code(h_code),
    .pkt_count(h_pc), .err_count(h_ec)
  );

  packet_receiver #(.BINARY(1), .TIMEOUT_CYCLES(100)) u_bin (
    .clk(clk), .reset(reset), .rx_data(b_data), .rx_valid(b_valid),
    .payload(b_payload), .timestamp(b_ts), .tick(b_tick),
    .pkt_valid(b_pv), .pkt_error(b_pe), .error_code(b_code),
    .pkt_count(b_pc), .err_count(b_ec)
  );

  // Pulse counters, used to check "exactly one pulse per packet".
  int unsigned h_vp = 0, h_ep = 0, b_vp = 0, b_ep = 0;
  always @(posedge clk) begin
    if (h_pv) h_vp <= h_vp + 1;
    if (h_pe) h_ep <= h_ep + 1;
    if (b_pv) b_vp <= b_vp + 1;
    if (b_pe) b_ep <= b_ep + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: last good fields, counters, last error.
  logic [63:0] hm_pay, hm_ts, bm_pay, bm_ts;
  logic [15:0] hm_tick, hm_pc, hm_ec, bm_tick, bm_pc, bm_ec;
  logic [2:0]  hm_code, bm_code;

  logic [7:0] txq[$];
  logic [7:0] bq[$];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hm_pay = '0; hm_ts = '0; hm_tick = '0; hm_pc = '0; hm_ec = '0; hm_code = '0;
    bm_pay = '0; bm_ts = '0; bm_tick = '0; bm_pc = '0; bm_ec = '0; bm_code = '0;
  endtask

  function automatic bit hdr_good(input logic [63:0] h);
    return h[63:56] == 8'd8 && h[55:48] == 8'd1 && h[47:36] == 12'd0 &&
           h[35:28] == 8'd0 && h[27:20] == 8'd0 && h[16] == 1'b1;
  endfunction

  function automatic bit is_hex_c(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c <= "9") return 4'(c - 8'h30);
    if (c <= "F") return 4'(c - 8'h37);
    return 4'(c - 8'h57);
  endfunction

  function automatic logic [7:0] nib_char(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  function automatic logic [191:0] rand_pkt();
    logic [63:0] h;
    h = {8'd8, 8'd1, 12'd0, 8'd0, 8'd0, 3'($urandom_range(0, 7)), 1'b1, 16'($urandom)};
    return {h, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic build_hex(input logic [191:0] p, input int unsigned nnib,
                           input bit lower, input bit lead_cr);
    logic [191:0] s;
    s = p;
    txq.delete();
    if (lead_cr) txq.push_back(8'h0D);
    for (int unsigned i = 0; i < nnib; i++) begin
      if (i < HEX_N) begin
        txq.push_back(nib_char(s[191:188], lower));
        s = s << 4;
      end else begin
        txq.push_back(nib_char(4'($urandom_range(0, 15)), lower));
      end
    end
    txq.push_back(8'h0D);
  endtask

  // Packet-level classification from the link rules.
  task automatic model_hex(output bit ok, output logic [2:0] code, output logic [191:0] p);
    int unsigned i = 0;
    int unsigned k = 0;
    p = '0; ok = 1'b0; code = '0;
    while (i < txq.size() && txq[i] == 8'h0D) i++;
    while (i < txq.size() && txq[i] != 8'h0D && is_hex_c(txq[i])) begin
      if (k < HEX_N) p = {p[187:0], hex_val(txq[i])};
      k++; i++;
    end
    if (k > HEX_N)                            code = 3'd2;
    else if (i < txq.size() && txq[i] != 8'h0D) code = 3'd3;
    else if (k < HEX_N)                       code = 3'd1;
    else if (!hdr_good(p[191:128]))           code = 3'd5;
    else                                      ok = 1'b1;
  endtask

  task automatic hex_byte(input logic [7:0] b, input int unsigned gap);
    h_data = b; h_valid = 1'b1;
    @(posedge clk); #1;
    h_valid = 1'b0;
    for (int unsigned g = 0; g < gap; g++) begin @(posedge clk); #1; end
  endtask

  task automatic bin_byte(input logic [7:0] b, input int unsigned gap);
    b_data = b; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int unsigned g = 0; g < gap; g++) begin @(posedge clk); #1; end
  endtask

  task automatic run_hex(input string tag);
    bit ok; logic [2:0] code; logic [191:0] p;
    int unsigned vp0, ep0;
    model_hex(ok, code, p);
    vp0 = h_vp; ep0 = h_ep;
    for (int unsigned i = 0; i < txq.size(); i++)
      hex_byte(txq[i], (i == txq.size() - 1) ? 0 : $urandom_range(0, 2));
    @(posedge clk); #1;
    chk({tag, ".latency"}, h_pv, ok);
    repeat (3) @(posedge clk);
    #1;
    if (ok) begin
      hm_pay = p[127:64]; hm_ts = p[63:0]; hm_tick = p[143:128]; hm_pc++;
    end else begin
      hm_code = code; hm_ec++;
    end
    chk({tag, ".vpulses"}, h_vp - vp0, ok ? 1 : 0);
    chk({tag, ".epulses"}, h_ep - ep0, ok ? 0 : 1);
    chk({tag, ".code"}, h_code, hm_code);
    chk({tag, ".payload"}, h_payload, hm_pay);
    chk({tag, ".timestamp"}, h_ts, hm_ts);
    chk({tag, ".tick"}, h_tick, hm_tick);
    chk({tag, ".pkt_count"}, h_pc, hm_pc);
    chk({tag, ".err_count"}, h_ec, hm_ec);
  endtask

  task automatic build_bin(input logic [191:0] p);
    logic [191:0] s;
    s = p;
    bq.delete();
    for (int i = 0; i < BIN_N; i++) begin
      bq.push_back(s[191:184]);
      s = s << 8;
    end
  endtask

  task automatic run_bin(input string tag);
    bit ok; logic [191:0] p;
    int unsigned vp0, ep0;
    p = '0;
    foreach (bq[i]) p = {p[183:0], bq[i]};
    ok = (bq.size() == BIN_N) && hdr_good(p[191:128]);
    vp0 = b_vp; ep0 = b_ep;
    for (int unsigned i = 0; i < bq.size(); i++)
      bin_byte(bq[i], (i == bq.size() - 1) ? 0 : $urandom_range(0, 2));
    @(posedge clk); #1;
    chk({tag, ".latency"}, b_pv, ok);
    repeat (3) @(posedge clk);
    #1;
    if (ok) begin
      bm_pay = p[127:64]; bm_ts = p[63:0]; bm_tick = p[143:128]; bm_pc++;
    end else begin
      bm_code = 3'd5; bm_ec++;
    end
    chk({tag, ".vpulses"}, b_vp - vp0, ok ? 1 : 0);
    chk({tag, ".epulses"}, b_ep - ep0, ok ? 0 : 1);
    chk({tag, ".code"}, b_code, bm_code);
    chk({tag, ".payload"}, b_payload, bm_pay);
    chk({tag, ".timestamp"}, b_ts, bm_ts);
    chk({tag, ".tick"}, b_tick, bm_tick);
    chk({tag, ".pkt_count"}, b_pc, bm_pc);
    chk({tag, ".err_count"}, b_ec, bm_ec);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".h_payload"}, h_payload, 0);
    chk({tag, ".h_ts"}, h_ts, 0);
    chk({tag, ".h_tick"}, h_tick, 0);
    chk({tag, ".h_flags"}, {h_pv, h_pe, h_code}, 0);
    chk({tag, ".h_counts"}, {h_pc, h_ec}, 0);
    chk({tag, ".b_payload"}, b_payload, 0);
    chk({tag, ".b_flags"}, {b_pv, b_pe, b_code}, 0);
    chk({tag, ".b_counts"}, {b_pc, b_ec}, 0);
  endtask

  logic [191:0] dpkt, p;
  logic [7:0]   badc;
  int unsigned  kind, pos, bit_i, ep0;

  initial begin
    reset = 1'b1; h_valid = 1'b0; b_valid = 1'b0; h_data = '0; b_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed hex packets
    dpkt = {64'h0801_0000_0001_0A5A, 64'h0123_4567_89AB_CDEF, 64'h1122_3344_5566_7788};
    build_hex(dpkt, HEX_N, 1'b0, 1'b0);
    run_hex("good_upper");
    chk("good_upper.payload_const", h_payload, 64'h0123_4567_89AB_CDEF);
    chk("good_upper.tick_const", h_tick, 16'h0A5A);

    build_hex(dpkt, HEX_N, 1'b1, 1'b1);
    run_hex("good_lower");

    build_hex(rand_pkt(), HEX_N - 1, 1'b0, 1'b0);
    run_hex("short");
    chk("short.code_const", h_code, 3'd1);

    build_hex(rand_pkt(), HEX_N + 1, 1'b0, 1'b0);
    run_hex("long");
    chk("long.code_const", h_code, 3'd2);
    build_hex(rand_pkt(), HEX_N, 1'b1, 1'b0);
    run_hex("after_long");

    p = dpkt;
    p[191:184] = 8'h18;
    build_hex(p, HEX_N, 1'b0, 1'b0);
    run_hex("hdr_res");
    chk("hdr_res.code_const", h_code, 3'd5);

    build_hex(rand_pkt(), HEX_N, 1'b0, 1'b0);
    txq[20] = "G";
    run_hex("badchar");

    // Randomized hex packets
    for (int n = 0; n < 16; n++) begin
      kind = $urandom_range(0, 9);
      p = rand_pkt();
      case (kind)
        5: build_hex(p, $urandom_range(1, HEX_N - 1), $urandom_range(0, 1), $urandom_range(0, 1));
        6: build_hex(p, $urandom_range(HEX_N + 1, HEX_N + 4), 1'b0, 1'b0);
        7: begin
          bit_i = $urandom_range(16, 63);
          if (bit_i >= 17 && bit_i <= 19) bit_i = 16;
          p[128 + bit_i] = ~p[128 + bit_i];
          build_hex(p, HEX_N, $urandom_range(0, 1), 1'b0);
        end
        8: begin
          build_hex(p, HEX_N, 1'b0, 1'b0);
          pos = $urandom_range(0, HEX_N - 1);
          case ($urandom_range(0, 5))
            0: badc = "/";
            1: badc = ":";
            2: badc = "@";
            3: badc = "G";
            4: badc = 8'h60;
            default: badc = "g";
          endcase
          txq[pos] = badc;
        end
        default: build_hex(p, HEX_N, $urandom_range(0, 1), $urandom_range(0, 1));
      endcase
      run_hex($sformatf("hex_rand%0d", n));
    end

    // Binary: 10 bytes then a stall of exactly TIMEOUT_CYCLES
    ep0 = b_ep;
    for (int i = 0; i < 10; i++) bin_byte(8'($urandom), 0);
    repeat (99) @(posedge clk);
    #1;
    chk("timeout.not_yet", {b_pe, b_code}, {1'b0, bm_code});
    @(posedge clk); #1;
    chk("timeout.pulse", b_pe, 1'b1);
    chk("timeout.code", b_code, 3'd4);
    bm_code = 3'd4; bm_ec++;
    repeat (2) @(posedge clk);
    #1;
    chk("timeout.epulses", b_ep - ep0, 1);
    build_bin(rand_pkt());
    run_bin("bin_after_timeout");

    for (int n = 0; n < 8; n++) begin
      p = rand_pkt();
      if ($urandom_range(0, 3) == 0) begin
        bit_i = $urandom_range(20, 63);
        p[128 + bit_i] = ~p[128 + bit_i];
      end
      build_bin(p);
      run_bin($sformatf("bin_rand%0d", n));
    end

    // Reset in the middle of a hex packet
    build_hex(rand_pkt(), HEX_N, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) hex_byte(txq[i], 0);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_reset_state("midreset");
    reset = 1'b0;
    @(posedge clk); #1;
    build_hex(rand_pkt(), HEX_N, 1'b0, 1'b0);
    run_hex("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
